// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port driven by the serial loader.
// One strobe per assembled word; address and data are valid with the strobe.
interface uart_imem_loader_if;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        input imem_we,
        input imem_addr,
        input imem_wdata
    );
endinterface

// File: rtl/uart_imem_loader.sv
// UART (8N1) program loader: receives a length-prefixed little-endian word stream
// and writes it into instruction memory while holding the processor in reset.
module uart_imem_loader #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       uart_rx,
    input  logic                       start,
    uart_imem_loader_if.master         imem,
    output logic                       busy,
    output logic                       cpu_hold,
    output logic                       done,
    output logic                       frame_error,
    output logic                       len_error,
    output logic [15:0]                word_count
);

    localparam int                CPB       = CLK_FREQ / BAUD;
    localparam int                CNT_W     = $clog2(CPB + 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [16:0]       DEPTH_LIM = 17'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        L_IDLE   = 3'd0,
        L_LEN_LO = 3'd1,
        L_LEN_HI = 3'd2,
        L_DATA   = 3'd3,
        L_DONE   = 3'd4,
        L_ERROR  = 3'd5
    } ld_state_t;

    // Receiver state
    logic             rx_meta_q, rx_s_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    // Loader state
    ld_state_t        ld_state_q, ld_state_d;
    logic [15:0]      len_q, len_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             frame_error_q, frame_error_d;
    logic             len_error_q, len_error_d;
    logic [15:0]      word_count_q, word_count_d;

    logic [15:0]      len_full_s;
    logic [15:0]      wc_inc_s;

    assign len_full_s = {shift_q, len_q[7:0]};
    assign wc_inc_s   = word_count_q + 16'd1;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Bit receiver state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q   <= R_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Bit receiver next state: mid-bit sampling, LSB first.
    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                clk_cnt_d = '0;
                // A line still low after a bad stop bit never shows a falling edge.
                if (rx_prev_q && !rx_s_q) begin
                    rx_state_d = R_START;
                    bit_cnt_d  = 3'd0;
                end else begin
                    rx_state_d = R_IDLE;
                end
            end
            R_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = rx_s_q ? R_IDLE : R_DATA;
                end else begin
                    rx_state_d = R_START;
                end
            end
            R_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        rx_state_d = R_DATA;
                    end
                end else begin
                    rx_state_d = R_DATA;
                end
            end
            R_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d    = '0;
                    byte_valid_d = rx_s_q;
                    frame_err_d  = !rx_s_q;
                    rx_state_d   = R_IDLE;
                end else begin
                    rx_state_d = R_STOP;
                end
            end
            default: begin
                rx_state_d = R_IDLE;
                clk_cnt_d  = '0;
            end
        endcase
    end

    // Loader state register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_state_q    <= L_IDLE;
            len_q         <= 16'd0;
            byte_idx_q    <= 2'd0;
            b0_q          <= 8'd0;
            b1_q          <= 8'd0;
            b2_q          <= 8'd0;
            we_q          <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_error_q <= 1'b0;
            len_error_q   <= 1'b0;
            word_count_q  <= 16'd0;
        end else begin
            ld_state_q    <= ld_state_d;
            len_q         <= len_d;
            byte_idx_q    <= byte_idx_d;
            b0_q          <= b0_d;
            b1_q          <= b1_d;
            b2_q          <= b2_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            frame_error_q <= frame_error_d;
            len_error_q   <= len_error_d;
            word_count_q  <= word_count_d;
        end
    end

    // Loader next state: length header, word assembly, write strobe, completion.
    always_comb begin
        ld_state_d    = ld_state_q;
        len_d         = len_q;
        byte_idx_d    = byte_idx_q;
        b0_d          = b0_q;
        b1_d          = b1_q;
        b2_d          = b2_q;
        we_d          = 1'b0;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        busy_d        = busy_q;
        done_d        = done_q;
        frame_error_d = frame_error_q;
        len_error_d   = len_error_q;
        word_count_d  = word_count_q;
        case (ld_state_q)
            L_IDLE, L_DONE, L_ERROR: begin
                if (start) begin
                    ld_state_d    = L_LEN_LO;
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    frame_error_d = 1'b0;
                    len_error_d   = 1'b0;
                    word_count_d  = 16'd0;
                    byte_idx_d    = 2'd0;
                end else begin
                    ld_state_d = ld_state_q;
                end
            end
            L_LEN_LO: begin
                if (frame_err_q) begin
                    ld_state_d    = L_ERROR;
                    frame_error_d = 1'b1;
                    busy_d        = 1'b0;
                end else if (byte_valid_q) begin
                    len_d      = {8'd0, shift_q};
                    ld_state_d = L_LEN_HI;
                end else begin
                    ld_state_d = L_LEN_LO;
                end
            end
            L_LEN_HI: begin
                if (frame_err_q) begin
                    ld_state_d    = L_ERROR;
                    frame_error_d = 1'b1;
                    busy_d        = 1'b0;
                end else if (byte_valid_q) begin
                    len_d = len_full_s;
                    if (len_full_s == 16'd0) begin
                        ld_state_d = L_DONE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                    end else if ({1'b0, len_full_s} > DEPTH_LIM) begin
                        ld_state_d  = L_ERROR;
                        len_error_d = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        ld_state_d = L_DATA;
                    end
                end else begin
                    ld_state_d = L_LEN_HI;
                end
            end
            L_DATA: begin
                // The strobe cycle commits the word; the count becomes visible one cycle later.
                if (we_q) begin
                    word_count_d = wc_inc_s;
                    if (wc_inc_s == len_q) begin
                        ld_state_d = L_DONE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        ld_state_d = L_DATA;
                    end
                end else if (frame_err_q) begin
                    ld_state_d    = L_ERROR;
                    frame_error_d = 1'b1;
                    busy_d        = 1'b0;
                end else if (byte_valid_q) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0:    b0_d = shift_q;
                        2'd1:    b1_d = shift_q;
                        2'd2:    b2_d = shift_q;
                        2'd3: begin
                            we_d    = 1'b1;
                            addr_d  = {14'd0, word_count_q, 2'b00};
                            wdata_d = {shift_q, b2_q, b1_q, b0_q};
                        end
                        default: byte_idx_d = 2'd0;
                    endcase
                end else begin
                    ld_state_d = L_DATA;
                end
            end
            default: begin
                ld_state_d = L_IDLE;
                busy_d     = 1'b0;
            end
        endcase
    end

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;
    assign busy            = busy_q;
    assign cpu_hold        = busy_q;
    assign done            = done_q;
    assign frame_error     = frame_error_q;
    assign len_error       = len_error_q;
    assign word_count      = word_count_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomized scoreboard bench for uart_imem_loader: stimulus pushes expected
// memory writes, an independent monitor pops and compares each write strobe.
module tb_uart_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        start = 1'b0;
    logic        busy, cpu_hold, done, frame_error, len_error;
    logic [15:0] word_count;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic        we_prev = 1'b0;

    uart_imem_loader_if imem_bus ();

    uart_imem_loader #(
        .CLK_FREQ   (1600),
        .BAUD       (100),
        .DEPTH_WORDS(256)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .uart_rx    (uart_rx),
        .start      (start),
        .imem       (imem_bus),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .frame_error(frame_error),
        .len_error  (len_error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_bus.imem_we === 1'b1) begin
            check("we_single_cycle", {31'd0, we_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                         imem_bus.imem_addr, imem_bus.imem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("write_addr", imem_bus.imem_addr, e[63:32]);
                check("write_data", imem_bus.imem_wdata, e[31:0]);
            end
        end
        we_prev = imem_bus.imem_we;
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // 8N1 frame, 16 clocks per bit, followed by idle line.
    task automatic send_byte(logic [7:0] b, logic stop_bit = 1'b1);
        uart_rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(16);
        end
        uart_rx = stop_bit;
        tick(16);
        uart_rx = 1'b1;
        tick(24);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Reference model: word w of a valid load lands at byte address 4*w as {b3,b2,b1,b0}.
    task automatic send_stream(logic [15:0] n, byte_q_t data, int start_at_word);
        if (n >= 16'd1 && n <= 16'd256) begin
            for (int w = 0; w < int'(n); w++) begin
                if (4 * w + 3 < data.size()) begin
                    exp_q.push_back({32'(w * 4), data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]});
                end
            end
        end
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < data.size(); i++) begin
            if (start_at_word > 0 && i == start_at_word * 4) begin
                pulse_start();
                check("busy_after_ignored_start", {31'd0, busy}, 32'd1);
            end
            send_byte(data[i]);
        end
    endtask

    task automatic wait_not_busy();
        int k = 0;
        while (busy && k < 400) begin
            tick(1);
            k++;
        end
        check("wait_not_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_frame_error"}, {31'd0, frame_error}, 32'd0);
        check({tag, "_len_error"}, {31'd0, len_error}, 32'd0);
        check({tag, "_word_count"}, {16'd0, word_count}, 32'd0);
        check({tag, "_imem_we"}, {31'd0, imem_bus.imem_we}, 32'd0);
        check({tag, "_imem_addr"}, imem_bus.imem_addr, 32'd0);
        check({tag, "_imem_wdata"}, imem_bus.imem_wdata, 32'd0);
    endtask

    task automatic check_done(string tag, int n);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_word_count"}, {16'd0, word_count}, 32'(n));
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        byte_q_t d;
        int      n;

        // Reset state
        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(5);

        // Two-word load
        pulse_start();
        check("load2_busy", {31'd0, busy}, 32'd1);
        check("load2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        d = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
        send_stream(16'd2, d, 0);
        wait_not_busy();
        check_done("load2", 2);

        // Zero length
        pulse_start();
        d = {};
        send_stream(16'd0, d, 0);
        wait_not_busy();
        check_done("zero_len", 0);

        // Length overflow: N=257, followed by four bytes that must not be written
        pulse_start();
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_stream(16'd257, d, 0);
        check("ovf_len_error", {31'd0, len_error}, 32'd1);
        check("ovf_busy", {31'd0, busy}, 32'd0);
        check("ovf_done", {31'd0, done}, 32'd0);
        check("ovf_word_count", {16'd0, word_count}, 32'd0);

        // Framing error on the first data byte
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h55, 1'b0);
        check("frm_frame_error", {31'd0, frame_error}, 32'd1);
        check("frm_busy", {31'd0, busy}, 32'd0);
        check("frm_done", {31'd0, done}, 32'd0);
        pulse_start();
        check("restart_frame_error", {31'd0, frame_error}, 32'd0);
        check("restart_len_error", {31'd0, len_error}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);

        // Glitch must not register as a length byte
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(40);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        check("glitch_len_error", {31'd0, len_error}, 32'd0);
        check("glitch_word_count", {16'd0, word_count}, 32'd0);

        // Mid-load reset clears everything asynchronously
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(3);
        reset_n = 1'b1;
        tick(3);
        pulse_start();
        d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_stream(16'd1, d, 0);
        wait_not_busy();
        check_done("reload", 1);

        // Start while busy is ignored; several randomized loads
        for (int it = 0; it < 4; it++) begin
            n = (it == 0) ? int'($urandom_range(2, 5)) : int'($urandom_range(1, 6));
            d = {};
            for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom_range(0, 255)));
            pulse_start();
            send_stream(16'(n), d, (it == 0) ? 1 : 0);
            wait_not_busy();
            check_done("rand_load", n);
        end

        tick(20);
        check("final_pending_writes", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
